addsub_issue_stage: RTL and testbench
=====================================

Name: addsub_issue_stage

Overview:
Front-end stage that buffers operand requests and drives the 6-bit Adder_Subtractor. It accepts {A, B, S} transactions over a valid/ready handshake into a 2-entry FIFO. It presents the FIFO head to the adder, registers the adder's answer together with overflow and self-check flags, and hands the result downstream over a second valid/ready handshake.

Parameters:
W, 6, operand/result width; must match the Adder_Subtractor width
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream request valid
in_ready  output  1  stage can accept a request (FIFO not full)
in_a  input  W  operand A
in_b  input  W  operand B
in_sub  input  1  0 = add, 1 = subtract (A-B)
addsub_a  output  W  to Adder_Subtractor A
addsub_b  output  W  to Adder_Subtractor B
addsub_s  output  1  to Adder_Subtractor S
addsub_answer  input  W  from Adder_Subtractor ANSWER (combinational)
out_valid  output  1  result register holds a result
out_ready  input  1  downstream accepts the result
out_answer  output  W  registered answer
out_ovf  output  1  signed overflow for this result
err_mismatch  output  1  sticky: adder answer differed from internal reference
op_count  output  CNT_W  number of results accepted downstream, wraps

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; in_ready=1.
  - out_valid=0, out_answer=0, out_ovf=0, err_mismatch=0, op_count=0.
  - addsub_a/b/s=0.
  - Takes effect mid-operation immediately and discards all buffered and in-flight requests.
- FIFO:
  - 2 entries of {A, B, S}; wr/rd pointers wrap mod 2; occupancy 0..2.
  - Push on in_valid && in_ready. in_ready = (occupancy < 2), registered-state based with no combinational path from out_ready.
- Issue:
  - addsub_a/b/s drive the FIFO head combinationally. When the FIFO is empty they hold the last-issued values (0 after reset).
  - fire = FIFO non-empty && (!out_valid || out_ready).
  - On fire, at the clock edge: pop head; out_answer <= addsub_answer; out_ovf <= computed flag; out_valid <= 1.
- Drain:
  - out_valid && out_ready with no fire: out_valid <= 0.
  - op_count increments on every out_valid && out_ready, wrapping 2^CNT_W-1 -> 0.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged. A push into a full FIFO is impossible because in_ready=0.
  - Push and fire on the same edge are both legal. The new entry lands behind the head.
- Latency:
  - A request accepted at edge N into an empty FIFO, with the output register free, is presented at edge N. out_valid is 1 after edge N+1.
  - Throughput is 1 result/cycle while out_ready=1.
- Overflow (two's complement, a/b = head operands, r = addsub_answer, MSB = bit W-1):
  - S=0: ovf = (a.MSB == b.MSB) && (r.MSB != a.MSB).
  - S=1: ovf = (a.MSB != b.MSB) && (r.MSB != a.MSB).
- Self-check:
  - On fire, compare r with the internally computed (a + b) mod 2^W or (a - b) mod 2^W.
  - On inequality, err_mismatch <= 1 and stays set until reset.
- out_answer/out_ovf are stable while out_valid && !out_ready.

Test Plan:
- Reset then push A=40, B=40, S=0 with out_ready=1 -> next edge out_valid=1, out_answer=6'b010000 (16), out_ovf=1, err_mismatch=0; op_count=1 after drain.
- Push A=5, B=9, S=1 -> out_answer=6'b111100 (60), out_ovf=0; push A=31, B=1, S=0 -> out_answer=6'b100000, out_ovf=1.
- Backpressure with out_ready=0, 4 back-to-back pushes of distinct values -> first 3 accepted (1 in output register, 2 in FIFO), in_ready=0 at the 4th. Output holds the first result stable. Raise out_ready -> results emerge in order, one per cycle; op_count=3 once the FIFO is empty and the last result is drained.
- Bench forces addsub_answer to a wrong value for one issued op -> err_mismatch=1 from the next edge onward. It stays set through later correct ops; only rst_n clears it.
- Assert rst_n low asynchronously (between edges) with 2 FIFO entries and out_valid=1 -> immediately out_valid=0, in_ready=1, op_count=0. After release, no stale result appears.
- op_count wrap: drain 256 results -> op_count returns to 0.

Source files
------------

// File: rtl/addsub_issue_stage_if.sv
// Handshake and adder-side bundle for addsub_issue_stage.
// The slave side is the stage; the master side is its environment, which includes the external adder.
interface addsub_issue_stage_if #(
  parameter int W     = 6,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_sub;
  logic [W-1:0]     addsub_a;
  logic [W-1:0]     addsub_b;
  logic             addsub_s;
  logic [W-1:0]     addsub_answer;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_answer;
  logic             out_ovf;
  logic             err_mismatch;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_a, in_b, in_sub, addsub_answer, out_ready,
    input  in_ready, addsub_a, addsub_b, addsub_s, out_valid, out_answer,
           out_ovf, err_mismatch, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, addsub_answer, out_ready,
    output in_ready, addsub_a, addsub_b, addsub_s, out_valid, out_answer,
           out_ovf, err_mismatch, op_count
  );
endinterface

// File: rtl/addsub_issue_stage.sv
// Issue stage for the W-bit Adder_Subtractor: a 2-entry request FIFO feeds the adder,
// and the result register captures its answer, an overflow flag and a sticky self-check flag.
module addsub_issue_stage #(
  parameter int W     = 6,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  addsub_issue_stage_if.slave bus
);

  // Reference answer used to cross-check the external adder
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [W-1:0] r;
    if (s) begin
      r = a - b;
    end else begin
      r = a + b;
    end
    return r;
  endfunction

  // Two's-complement overflow from the operand and result sign bits
  function automatic logic ovf_flag(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, input logic [W-1:0] r);
    logic f;
    if (s) begin
      f = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      f = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return f;
  endfunction

  logic [W-1:0]     fifo_a_r [2];
  logic [W-1:0]     fifo_b_r [2];
  logic             fifo_s_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic [W-1:0]     last_a_r;
  logic [W-1:0]     last_b_r;
  logic             last_s_r;
  logic             out_valid_r;
  logic [W-1:0]     out_answer_r;
  logic             out_ovf_r;
  logic             err_r;
  logic [CNT_W-1:0] op_count_r;

  logic             empty_s;
  logic             in_ready_s;
  logic             push_s;
  logic             fire_s;
  logic             drain_s;
  logic [W-1:0]     head_a_s;
  logic [W-1:0]     head_b_s;
  logic             head_s_s;
  logic [W-1:0]     issue_a_s;
  logic [W-1:0]     issue_b_s;
  logic             issue_s_s;

  // Handshake decode, head selection and next occupancy
  always_comb begin
    empty_s    = (count_r == 2'd0);
    in_ready_s = (count_r != 2'd2);
    push_s     = bus.in_valid && in_ready_s;
    fire_s     = !empty_s && (!out_valid_r || bus.out_ready);
    drain_s    = out_valid_r && bus.out_ready;
    head_a_s   = fifo_a_r[rd_ptr_r];
    head_b_s   = fifo_b_r[rd_ptr_r];
    head_s_s   = fifo_s_r[rd_ptr_r];
    // An empty FIFO keeps the adder inputs parked on the last issued request
    if (empty_s) begin
      issue_a_s = last_a_r;
      issue_b_s = last_b_r;
      issue_s_s = last_s_r;
    end else begin
      issue_a_s = head_a_s;
      issue_b_s = head_b_s;
      issue_s_s = head_s_s;
    end
    case ({push_s, fire_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Request FIFO storage, pointers and last-issued operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_a_r[0] <= '0;
      fifo_a_r[1] <= '0;
      fifo_b_r[0] <= '0;
      fifo_b_r[1] <= '0;
      fifo_s_r[0] <= 1'b0;
      fifo_s_r[1] <= 1'b0;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      last_a_r    <= '0;
      last_b_r    <= '0;
      last_s_r    <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_a_r[wr_ptr_r] <= bus.in_a;
        fifo_b_r[wr_ptr_r] <= bus.in_b;
        fifo_s_r[wr_ptr_r] <= bus.in_sub;
        wr_ptr_r           <= ~wr_ptr_r;
      end
      if (fire_s) begin
        rd_ptr_r <= ~rd_ptr_r;
        last_a_r <= head_a_s;
        last_b_r <= head_b_s;
        last_s_r <= head_s_s;
      end
      count_r <= count_nxt_s;
    end
  end

  // Result register, completion counter and sticky self-check flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_answer_r <= '0;
      out_ovf_r    <= 1'b0;
      err_r        <= 1'b0;
      op_count_r   <= '0;
    end else begin
      if (fire_s) begin
        out_valid_r  <= 1'b1;
        out_answer_r <= bus.addsub_answer;
        out_ovf_r    <= ovf_flag(head_a_s, head_b_s, head_s_s, bus.addsub_answer);
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end
      if (drain_s) begin
        op_count_r <= op_count_r + CNT_W'(1);
      end
      if (fire_s && (bus.addsub_answer != ref_result(head_a_s, head_b_s, head_s_s))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.addsub_a     = issue_a_s;
  assign bus.addsub_b     = issue_b_s;
  assign bus.addsub_s     = issue_s_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_answer   = out_answer_r;
  assign bus.out_ovf      = out_ovf_r;
  assign bus.err_mismatch = err_r;
  assign bus.op_count     = op_count_r;

endmodule

// File: tb/tb_addsub_issue_stage.sv
// Directed bench for addsub_issue_stage; it also stands in for the external 6-bit adder.
module tb_addsub_issue_stage;

  logic clk;
  logic rst_n;
  logic corrupt;
  int   n_checks;
  int   n_fail;
  int   exp_cnt;
  logic not_ready_seen;

  addsub_issue_stage_if #(.W(6), .CNT_W(8)) bus ();

  addsub_issue_stage #(.W(6), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] adder_model;
  assign adder_model       = bus.addsub_s ? (bus.addsub_a - bus.addsub_b) : (bus.addsub_a + bus.addsub_b);
  assign bus.addsub_answer = corrupt ? (adder_model ^ 6'b000001) : adder_model;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic       s;
    logic [5:0] ans;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b, input logic s);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = s;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    corrupt  = 1'b0;
    rst_n    = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 1'b0);

    vecs[0] = '{6'd40, 6'd40, 1'b0, 6'd16, 1'b1};
    vecs[1] = '{6'd5,  6'd9,  1'b1, 6'd60, 1'b0};
    vecs[2] = '{6'd31, 6'd1,  1'b0, 6'd32, 1'b1};
    vecs[3] = '{6'd10, 6'd20, 1'b1, 6'd54, 1'b0};
    vecs[4] = '{6'd32, 6'd1,  1'b1, 6'd31, 1'b1};
    vecs[5] = '{6'd63, 6'd63, 1'b0, 6'd62, 1'b0};
    vecs[6] = '{6'd20, 6'd11, 1'b0, 6'd31, 1'b0};
    vecs[7] = '{6'd0,  6'd0,  1'b1, 6'd0,  1'b0};

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    check("rst_in_ready",   32'(bus.in_ready),     32'd1);
    check("rst_out_valid",  32'(bus.out_valid),    32'd0);
    check("rst_out_answer", 32'(bus.out_answer),   32'd0);
    check("rst_out_ovf",    32'(bus.out_ovf),      32'd0);
    check("rst_err",        32'(bus.err_mismatch), 32'd0);
    check("rst_op_count",   32'(bus.op_count),     32'd0);
    check("rst_addsub_a",   32'(bus.addsub_a),     32'd0);

    // Single-request vectors: push, present, capture, drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
      tick();
      bus.in_valid = 1'b0;
      check("issue_a", 32'(bus.addsub_a), 32'(vecs[i].a));
      check("issue_b", 32'(bus.addsub_b), 32'(vecs[i].b));
      check("issue_s", 32'(bus.addsub_s), 32'(vecs[i].s));
      tick();
      check("vec_out_valid", 32'(bus.out_valid),    32'd1);
      check("vec_answer",    32'(bus.out_answer),   32'(vecs[i].ans));
      check("vec_ovf",       32'(bus.out_ovf),      32'(vecs[i].ovf));
      check("vec_err",       32'(bus.err_mismatch), 32'd0);
      tick();
      exp_cnt++;
      check("vec_op_count",  32'(bus.op_count),  32'(exp_cnt));
      check("vec_drained",   32'(bus.out_valid), 32'd0);
      check("hold_last_a",   32'(bus.addsub_a),  32'(vecs[i].a));
    end

    // One corrupted adder answer sets the sticky error flag
    drive(1'b1, 6'd3, 6'd4, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    check("err_set", 32'(bus.err_mismatch), 32'd1);
    tick();
    drive(1'b1, vecs[1].a, vecs[1].b, vecs[1].s);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("err_good_answer", 32'(bus.out_answer),   32'd60);
    check("err_sticky",      32'(bus.err_mismatch), 32'd1);
    tick();
    check("err_sticky_cnt",  32'(bus.op_count),     32'd10);

    // Fill FIFO and output register, then reset between edges
    bus.out_ready = 1'b0;
    drive(1'b1, 6'd1, 6'd2, 1'b0);
    tick();
    drive(1'b1, 6'd10, 6'd3, 1'b1);
    tick();
    drive(1'b1, 6'd7, 6'd7, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid),    32'd0);
    check("async_in_ready",  32'(bus.in_ready),     32'd1);
    check("async_op_count",  32'(bus.op_count),     32'd0);
    check("async_err",       32'(bus.err_mismatch), 32'd0);
    check("async_answer",    32'(bus.out_answer),   32'd0);
    check("async_addsub_a",  32'(bus.addsub_a),     32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_valid", 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: three accepted, fourth refused, results drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 6'd1, 6'd2, 1'b0);
    tick();
    check("bp_ready1", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 6'd10, 6'd3, 1'b1);
    tick();
    check("bp_ready2", 32'(bus.in_ready),   32'd1);
    check("bp_valid",  32'(bus.out_valid),  32'd1);
    check("bp_first",  32'(bus.out_answer), 32'd3);
    drive(1'b1, 6'd7, 6'd7, 1'b0);
    tick();
    check("bp_full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 6'd50, 6'd1, 1'b0);
    tick();
    check("bp_refused", 32'(bus.in_ready),   32'd0);
    check("bp_stable1", 32'(bus.out_answer), 32'd3);
    bus.in_valid = 1'b0;
    tick();
    check("bp_stable2", 32'(bus.out_answer), 32'd3);
    check("bp_hold_v",  32'(bus.out_valid),  32'd1);
    check("bp_no_cnt",  32'(bus.op_count),   32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_second",  32'(bus.out_answer), 32'd7);
    check("bp_cnt1",    32'(bus.op_count),   32'd1);
    tick();
    check("bp_third",   32'(bus.out_answer), 32'd14);
    check("bp_cnt2",    32'(bus.op_count),   32'd2);
    tick();
    check("bp_empty_v", 32'(bus.out_valid),  32'd0);
    check("bp_cnt3",    32'(bus.op_count),   32'd3);
    tick();
    check("bp_no_fourth", 32'(bus.out_valid), 32'd0);

    // Counter wrap over 256 back-to-back results
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    not_ready_seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 6'(i), 6'd1, 1'b0);
      if (!bus.in_ready) not_ready_seen = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("wrap_always_ready", 32'(not_ready_seen), 32'd0);
    tick();
    check("wrap_cnt255",  32'(bus.op_count),     32'd255);
    check("wrap_last",    32'(bus.out_answer),   32'd0);
    check("wrap_valid",   32'(bus.out_valid),    32'd1);
    tick();
    check("wrap_cnt0",    32'(bus.op_count),     32'd0);
    check("wrap_drained", 32'(bus.out_valid),    32'd0);
    check("wrap_err",     32'(bus.err_mismatch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
